dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the multicycle CPU core (MEM-state loads/stores)
//  and a DMA/loader requester. Grants one transaction at a time, drives the synchronous SRAM,
//  waits the fixed memory latency, returns read data and a one-cycle ack to the owning requester.
//  Sits between the core's dAddress/dWriteData/MemRead/MemWrite and the data SRAM.
// PARAMETERS
//  ADDR_W       32  address width, passed through unmodified; alignment is the requester's job
//  DATA_W       32  data width
//  MEM_LATENCY  1   cycles from the mem_en cycle to the cycle mem_rdata is valid; legal 1..7
//  ARB_MODE     1   0 = fixed priority, CPU wins; 1 = round-robin between CPU and DMA
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  cpu_req    in   1       CPU request; held with cpu_we/addr/wdata stable until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_rdata  out  DATA_W  read data; valid with cpu_ack, held until next CPU read ack
//  dma_req/dma_we/dma_addr/dma_wdata/dma_ack/dma_rdata  same as the cpu_* set, for DMA
//  mem_en     out  1       SRAM access strobe, high exactly one cycle per transaction
//  mem_we     out  1       SRAM write enable, valid only with mem_en
//  mem_addr   out  ADDR_W  SRAM address, valid with mem_en
//  mem_wdata  out  DATA_W  SRAM write data, valid with mem_en
//  mem_rdata  in   DATA_W  SRAM read data, valid MEM_LATENCY cycles after mem_en
//  busy       out  1       high in every state except IDLE
//  owner      out  1       0 = CPU, 1 = DMA; current/last granted port
// BEHAVIOUR
//  Reset: state IDLE; all acks, mem_en, mem_we, busy, owner = 0; rdata regs and latched
//   addr/wdata = 0; last_owner = DMA (CPU wins first RR tie).
//  FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, registered.
//   IDLE:  if any req, pick winner, latch we/addr/wdata/owner, load cnt = MEM_LATENCY-1, go ISSUE.
//   ISSUE: mem_en = 1, mem_we/addr/wdata from latches; go WAIT.
//   WAIT:  if cnt == 0, capture mem_rdata into the owner's rdata reg (reads only), go DONE;
//          else cnt--.
//   DONE:  owner's ack = 1 for this cycle only; last_owner <= owner; go IDLE.
//  Timing (req seen in IDLE = cycle 0): mem_en cycle 1, capture cycle 1+MEM_LATENCY, ack cycle
//   2+MEM_LATENCY. Reads and writes use identical timing. Throughput: one transaction per
//   MEM_LATENCY+3 cycles.
//  Arbitration (IDLE only): single req -> that port. Both: ARB_MODE 0 -> CPU; ARB_MODE 1 ->
//   the port != last_owner. No preemption once granted.
//  req dropped after grant: transaction still completes and ack still pulses. req still high in
//   the cycle after ack is a new request. The non-owner never sees ack.
//  Writes leave the owner's rdata reg unchanged. mem_we = 0 whenever mem_en = 0.
//  rst mid-transaction: immediate return to IDLE; mem_en/acks drop asynchronously; the in-flight
//   transaction is discarded with no ack. Requesters reissue.
//  mem_rdata outside the capture cycle is ignored. MEM_LATENCY outside 1..7 is a
//   synthesis-time error.
// TESTING
//  1 rst pulse mid-sim -> all outputs 0, busy = 0, next CPU/DMA tie (RR) grants CPU.
//  2 LAT=1, CPU write 0x10 <- 0xDEADBEEF -> cycle 1 mem_en = mem_we = 1, mem_addr = 0x10;
//    cpu_ack cycle 3; dma_ack stays 0.
//  3 LAT=1, CPU read 0x10, SRAM model returns 0xDEADBEEF -> cpu_ack cycle 3 with
//    cpu_rdata = 0xDEADBEEF, held after.
//  4 Both req held high, ARB_MODE=1 -> owners CPU, DMA, CPU, DMA; ARB_MODE=0 -> CPU every grant.
//  5 LAT=3, DMA read 0x40 -> mem_en cycle 1, capture cycle 4, dma_ack cycle 5.
//  6 rst asserted during WAIT -> mem_en/acks 0 at once, no ack; reissued req completes normally.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one synchronous data-SRAM port between the CPU core and a DMA
// requester. One transaction is in flight at a time:
// IDLE (grant + latch) -> ISSUE (mem_en) -> WAIT (latency) -> DONE (ack) -> IDLE.
//
// Ports
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata            one-cycle completion pulse, last CPU read data
//   dma_req/we/addr/wdata         DMA request, same contract as the CPU set
//   dma_ack, dma_rdata            one-cycle completion pulse, last DMA read data
//   mem_en/we/addr/wdata          SRAM strobe (one cycle per transaction) and command
//   mem_rdata                     SRAM read data, valid MEM_LATENCY cycles after mem_en
//   busy                          high whenever the FSM is not idle
//   owner                         0 = CPU, 1 = DMA; current or last granted port
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ARB_MODE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
    $error("dmem_port_arbiter: MEM_LATENCY must be in 1..7");
  end

  localparam logic [2:0] CntLoad = 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              grant_dma;

  // DMA wins when it is alone, or on a round-robin tie when the CPU had the last grant.
  always_comb begin
    grant_dma = dma_req && (!cpu_req || (ARB_MODE != 0 && !last_owner_q));
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || dma_req) begin
          owner_d = grant_dma;
          we_d    = grant_dma ? dma_we    : cpu_we;
          addr_d  = grant_dma ? dma_addr  : cpu_addr;
          wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          cnt_d   = CntLoad;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (cnt_q == 3'd0) begin
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;  // CPU takes the first round-robin tie
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cnt_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs decode straight from the state register so reset drops them immediately.
  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_ack   = (state_q == StDone) && !owner_q;
    dma_ack   = (state_q == StDone) && owner_q;
    busy      = (state_q != StIdle);
    owner     = owner_q;
    cpu_rdata = cpu_rdata_q;
    dma_rdata = dma_rdata_q;
  end

endmodule
